defect_extreme_points_roi: RTL

// Per-frame defect locator on the binarised pixel stream; successor to the

---
 rtl/defect_extreme_points_roi.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/defect_extreme_points_roi.sv
// Per-frame defect locator on a binarised pixel stream.
// Inside a ROI it tracks the leftmost, rightmost, topmost and bottommost defect pixels and counts
// the defect pixels. The results for frame N are published on the rising edge of bin2_vs that
// starts frame N+1 and are held until the next publish.
// Ports:
//   pixclk_in, rst_n             clock, asynchronous active-low reset
//   bin2_vs/bin2_de/bin2_data    frame sync, pixel valid, defect bit
//   roi_x0/x1/y0/y1, min_area    ROI (inclusive) and noise floor; sampled at frame start
//   defect_pN_x/y                N=1..4: leftmost, rightmost, topmost, bottommost
//   defect_area, defect_valid    last frame's count (saturating) and area >= min_area, area != 0
//   frame_done                   1-cycle pulse, coincident with the outputs updating
//   point_vs, point_de           bin2_vs/bin2_de delayed DELAY_CYCLES clocks
module defect_extreme_points_roi #(
  parameter int unsigned IMG_WIDTH    = 640,
  parameter int unsigned IMG_HEIGHT   = 480,
  parameter int unsigned COORD_WID    = 11,
  parameter int unsigned AREA_WID     = 20,
  parameter int unsigned DELAY_CYCLES = 1
) (
  input  logic                 pixclk_in,
  input  logic                 rst_n,
  input  logic                 bin2_vs,
  input  logic                 bin2_de,
  input  logic                 bin2_data,
  input  logic [COORD_WID-1:0] roi_x0,
  input  logic [COORD_WID-1:0] roi_x1,
  input  logic [COORD_WID-1:0] roi_y0,
  input  logic [COORD_WID-1:0] roi_y1,
  input  logic [AREA_WID-1:0]  min_area,
  output logic [COORD_WID-1:0] defect_p1_x,
  output logic [COORD_WID-1:0] defect_p1_y,
  output logic [COORD_WID-1:0] defect_p2_x,
  output logic [COORD_WID-1:0] defect_p2_y,
  output logic [COORD_WID-1:0] defect_p3_x,
  output logic [COORD_WID-1:0] defect_p3_y,
  output logic [COORD_WID-1:0] defect_p4_x,
  output logic [COORD_WID-1:0] defect_p4_y,
  output logic [AREA_WID-1:0]  defect_area,
  output logic                 defect_valid,
  output logic                 frame_done,
  output logic                 point_vs,
  output logic                 point_de
);

  localparam logic [COORD_WID-1:0] XLim = COORD_WID'(IMG_WIDTH);
  localparam logic [COORD_WID-1:0] YLim = COORD_WID'(IMG_HEIGHT);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic                 vs_d, de_d;
  logic [COORD_WID-1:0] x_cnt, y_cnt;
  logic [COORD_WID-1:0] rx0_q, rx1_q, ry0_q, ry1_q;
  logic [AREA_WID-1:0]  min_area_q;
  logic [COORD_WID-1:0] p1x_q, p1y_q, p2x_q, p2y_q, p3x_q, p3y_q, p4x_q, p4y_q;
  logic [COORD_WID-1:0] p1x_d, p1y_d, p2x_d, p2y_d, p3x_d, p3y_d, p4x_d, p4y_d;
  logic [AREA_WID-1:0]  area_q, area_d;
  logic [DELAY_CYCLES-1:0] vs_dly, de_dly;

  logic                 vs_rise, de_fall, publish, hit;
  logic [COORD_WID-1:0] x_pix, y_pix, rx0, rx1, ry0, ry1;

  assign vs_rise = bin2_vs & ~vs_d;
  assign de_fall = ~bin2_de & de_d;
  assign publish = (state_q == StActive) & vs_rise;

  // A pixel in the vs_rise cycle belongs to the new frame: row 0, and the freshly presented ROI.
  assign x_pix = x_cnt;
  assign y_pix = vs_rise ? '0 : y_cnt;
  assign rx0   = vs_rise ? roi_x0 : rx0_q;
  assign rx1   = vs_rise ? roi_x1 : rx1_q;
  assign ry0   = vs_rise ? roi_y0 : ry0_q;
  assign ry1   = vs_rise ? roi_y1 : ry1_q;

  // An inverted ROI fails one of the bound pairs, so it naturally counts nothing.
  assign hit = ((state_q == StActive) | vs_rise) & bin2_de & bin2_data &
               (x_pix < XLim) & (y_pix < YLim) &
               (x_pix >= rx0) & (x_pix <= rx1) & (y_pix >= ry0) & (y_pix <= ry1);

  always_comb begin
    state_d = state_q;
    if (vs_rise) state_d = StActive;
  end

  always_comb begin
    p1x_d = p1x_q; p1y_d = p1y_q; p2x_d = p2x_q; p2y_d = p2y_q;
    p3x_d = p3x_q; p3y_d = p3y_q; p4x_d = p4x_q; p4y_d = p4y_q;
    area_d = area_q;
    if (vs_rise) begin
      p1x_d = '0; p1y_d = '0; p2x_d = '0; p2y_d = '0;
      p3x_d = '0; p3y_d = '0; p4x_d = '0; p4y_d = '0;
      area_d = '0;
    end
    if (hit) begin
      // area saturates rather than wraps, so zero reliably means "nothing seen yet"
      if (area_d == '0) begin
        p1x_d = x_pix; p1y_d = y_pix; p2x_d = x_pix; p2y_d = y_pix;
        p3x_d = x_pix; p3y_d = y_pix; p4x_d = x_pix; p4y_d = y_pix;
      end else begin
        if (x_pix < p1x_d) begin p1x_d = x_pix; p1y_d = y_pix; end
        if (x_pix > p2x_d) begin p2x_d = x_pix; p2y_d = y_pix; end
        if (y_pix > p4y_d) begin p4x_d = x_pix; p4y_d = y_pix; end
      end
      if (area_d != '1) area_d = area_d + 1'b1;
    end
  end

  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vs_d       <= 1'b0;
      de_d       <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      rx0_q      <= '0;
      rx1_q      <= '0;
      ry0_q      <= '0;
      ry1_q      <= '0;
      min_area_q <= '0;
      p1x_q <= '0; p1y_q <= '0; p2x_q <= '0; p2y_q <= '0;
      p3x_q <= '0; p3y_q <= '0; p4x_q <= '0; p4y_q <= '0;
      area_q <= '0;
    end else begin
      state_q <= state_d;
      vs_d    <= bin2_vs;
      de_d    <= bin2_de;
      if (de_fall)                 x_cnt <= '0;
      else if (bin2_de && ~&x_cnt) x_cnt <= x_cnt + 1'b1;
      if (vs_rise)                 y_cnt <= '0;
      else if (de_fall && ~&y_cnt) y_cnt <= y_cnt + 1'b1;
      if (vs_rise) begin
        rx0_q      <= roi_x0;
        rx1_q      <= roi_x1;
        ry0_q      <= roi_y0;
        ry1_q      <= roi_y1;
        min_area_q <= min_area;
      end
      p1x_q <= p1x_d; p1y_q <= p1y_d; p2x_q <= p2x_d; p2y_q <= p2y_d;
      p3x_q <= p3x_d; p3y_q <= p3y_d; p4x_q <= p4x_d; p4y_q <= p4y_d;
      area_q <= area_d;
    end
  end

  // Result registers; min_area_q still holds the finishing frame's threshold at publish time.
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      defect_p1_x <= '0; defect_p1_y <= '0; defect_p2_x <= '0; defect_p2_y <= '0;
      defect_p3_x <= '0; defect_p3_y <= '0; defect_p4_x <= '0; defect_p4_y <= '0;
      defect_area  <= '0;
      defect_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= publish;
      if (publish) begin
        defect_p1_x <= p1x_q; defect_p1_y <= p1y_q; defect_p2_x <= p2x_q; defect_p2_y <= p2y_q;
        defect_p3_x <= p3x_q; defect_p3_y <= p3y_q; defect_p4_x <= p4x_q; defect_p4_y <= p4y_q;
        defect_area  <= area_q;
        defect_valid <= (area_q != '0) && (area_q >= min_area_q);
      end
    end
  end

  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      vs_dly <= '0;
      de_dly <= '0;
    end else begin
      vs_dly[0] <= bin2_vs;
      de_dly[0] <= bin2_de;
      for (int i = 1; i < int'(DELAY_CYCLES); i++) begin
        vs_dly[i] <= vs_dly[i-1];
        de_dly[i] <= de_dly[i-1];
      end
    end
  end

  assign point_vs = vs_dly[DELAY_CYCLES-1];
  assign point_de = de_dly[DELAY_CYCLES-1];

endmodule
